// File: rtl/dat_mem_requester.sv
// DAT memory requester: round-robin arbitration of CSR half-word accesses and
// controller full-entry reads onto a single-outstanding 64-bit memory port.
module dat_mem_requester #(
  parameter int unsigned DatAw         = 7,
  parameter int unsigned Depth         = 128,
  parameter int unsigned TimeoutCycles = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             csr_req_valid_i,
  output logic             csr_req_ready_o,
  input  logic             csr_req_write_i,
  input  logic [DatAw:0]   csr_req_addr_i,
  input  logic [31:0]      csr_req_wdata_i,
  output logic             csr_rsp_valid_o,
  input  logic             csr_rsp_ready_i,
  output logic [31:0]      csr_rsp_rdata_o,
  output logic             csr_rsp_error_o,
  input  logic             ctrl_req_valid_i,
  output logic             ctrl_req_ready_o,
  input  logic [DatAw-1:0] ctrl_req_idx_i,
  output logic             ctrl_rsp_valid_o,
  output logic [63:0]      ctrl_rsp_entry_o,
  output logic             ctrl_rsp_error_o,
  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic [DatAw-1:0] mem_addr_o,
  output logic [63:0]      mem_wdata_o,
  output logic [63:0]      mem_wmask_o,
  input  logic [63:0]      mem_rdata_i,
  input  logic             mem_rvalid_i,
  input  logic [1:0]       mem_rerror_i
);

  localparam int unsigned CntW  = 8;
  localparam int unsigned HalfW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    CSR_RSP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            last_ctrl_q;
  logic            owner_csr_q;
  logic            half_q;

  logic [DatAw-1:0] csr_idx;
  logic             csr_in_range, ctrl_in_range;
  logic             idle, grant_ctrl, grant_csr, csr_wr_ok, csr_rd_ok;
  logic             rd_timeout, rd_done, rd_err;
  logic [63:0]      rd_data;

  // Request decode and arbitration; ties go to whoever was not granted last.
  assign csr_idx       = csr_req_addr_i[DatAw:1];
  assign csr_in_range  = 32'(csr_idx) < Depth;
  assign ctrl_in_range = 32'(ctrl_req_idx_i) < Depth;
  assign idle          = (state_q == IDLE) && !rst_i;
  assign grant_ctrl    = idle && ctrl_req_valid_i && (!csr_req_valid_i || !last_ctrl_q);
  assign grant_csr     = idle && csr_req_valid_i && !grant_ctrl;
  assign csr_wr_ok     = csr_in_range && csr_req_write_i;
  assign csr_rd_ok     = csr_in_range && !csr_req_write_i;

  // Read completion: data beats the timeout when both land on the last wait cycle.
  assign rd_timeout = (state_q == RD_WAIT) && !mem_rvalid_i &&
                      (cnt_q == CntW'(TimeoutCycles - 1));
  assign rd_done    = (state_q == RD_WAIT) && (mem_rvalid_i || rd_timeout);
  assign rd_err     = rd_timeout || (|mem_rerror_i);
  assign rd_data    = rd_timeout ? 64'h0 : mem_rdata_i;

  assign csr_rsp_valid_o = (state_q == CSR_RSP);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_ctrl)     state_d = ctrl_in_range ? RD_WAIT : IDLE;
        else if (grant_csr) state_d = csr_rd_ok ? RD_WAIT : CSR_RSP;
      end
      RD_WAIT: if (rd_done) state_d = owner_csr_q ? CSR_RSP : IDLE;
      CSR_RSP: if (csr_rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and memory request strobes, valid only on the accept cycle.
  always_comb begin
    csr_req_ready_o  = 1'b0;
    ctrl_req_ready_o = 1'b0;
    mem_req_o        = 1'b0;
    mem_write_o      = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;
    mem_wmask_o      = '0;
    if (grant_ctrl) begin
      ctrl_req_ready_o = 1'b1;
      mem_req_o        = ctrl_in_range;
      mem_addr_o       = ctrl_req_idx_i;
    end else if (grant_csr) begin
      csr_req_ready_o = 1'b1;
      mem_req_o       = csr_in_range;
      mem_write_o     = csr_wr_ok;
      mem_addr_o      = csr_idx;
      if (csr_wr_ok) begin
        mem_wdata_o = {csr_req_wdata_i, csr_req_wdata_i};
        mem_wmask_o = csr_req_addr_i[0] ? {{HalfW{1'b1}}, {HalfW{1'b0}}}
                                        : {{HalfW{1'b0}}, {HalfW{1'b1}}};
      end
    end
  end

  // Transaction context, wait counter and registered responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q            <= '0;
      last_ctrl_q      <= 1'b0;
      owner_csr_q      <= 1'b0;
      half_q           <= 1'b0;
      ctrl_rsp_valid_o <= 1'b0;
      ctrl_rsp_entry_o <= '0;
      ctrl_rsp_error_o <= 1'b0;
      csr_rsp_rdata_o  <= '0;
      csr_rsp_error_o  <= 1'b0;
    end else begin
      ctrl_rsp_valid_o <= 1'b0;
      if (grant_ctrl || grant_csr) begin
        last_ctrl_q <= grant_ctrl;
        owner_csr_q <= grant_csr;
        half_q      <= csr_req_addr_i[0];
        cnt_q       <= '0;
      end
      if (grant_ctrl && !ctrl_in_range) begin
        ctrl_rsp_valid_o <= 1'b1;
        ctrl_rsp_entry_o <= '0;
        ctrl_rsp_error_o <= 1'b1;
      end
      if (grant_csr && !csr_rd_ok) begin
        csr_rsp_rdata_o <= '0;
        csr_rsp_error_o <= !csr_in_range;
      end
      if (state_q == RD_WAIT) begin
        if (!rd_done) begin
          cnt_q <= cnt_q + CntW'(1);
        end else if (owner_csr_q) begin
          csr_rsp_rdata_o <= half_q ? rd_data[2*HalfW-1:HalfW] : rd_data[HalfW-1:0];
          csr_rsp_error_o <= rd_err;
        end else begin
          ctrl_rsp_valid_o <= 1'b1;
          ctrl_rsp_entry_o <= rd_data;
          ctrl_rsp_error_o <= rd_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_dat_mem_requester.sv
// Bench for dat_mem_requester: vector table plus hand sequences, responses
// checked against a scoreboard queue by a monitor.
module tb_dat_mem_requester;

  localparam int unsigned DatAw = 8;
  localparam int unsigned Depth = 128;
  localparam int unsigned Tmo   = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             csr_req_valid, csr_req_ready, csr_req_write;
  logic [DatAw:0]   csr_req_addr;
  logic [31:0]      csr_req_wdata;
  logic             csr_rsp_valid, csr_rsp_ready, csr_rsp_error;
  logic [31:0]      csr_rsp_rdata;
  logic             ctrl_req_valid, ctrl_req_ready;
  logic [DatAw-1:0] ctrl_req_idx;
  logic             ctrl_rsp_valid, ctrl_rsp_error;
  logic [63:0]      ctrl_rsp_entry;
  logic             mem_req, mem_write;
  logic [DatAw-1:0] mem_addr;
  logic [63:0]      mem_wdata, mem_wmask, mem_rdata;
  logic             mem_rvalid;
  logic [1:0]       mem_rerror;

  dat_mem_requester #(.DatAw(DatAw), .Depth(Depth), .TimeoutCycles(Tmo)) dut (
    .clk_i(clk), .rst_i(rst),
    .csr_req_valid_i(csr_req_valid), .csr_req_ready_o(csr_req_ready),
    .csr_req_write_i(csr_req_write), .csr_req_addr_i(csr_req_addr),
    .csr_req_wdata_i(csr_req_wdata),
    .csr_rsp_valid_o(csr_rsp_valid), .csr_rsp_ready_i(csr_rsp_ready),
    .csr_rsp_rdata_o(csr_rsp_rdata), .csr_rsp_error_o(csr_rsp_error),
    .ctrl_req_valid_i(ctrl_req_valid), .ctrl_req_ready_o(ctrl_req_ready),
    .ctrl_req_idx_i(ctrl_req_idx),
    .ctrl_rsp_valid_o(ctrl_rsp_valid), .ctrl_rsp_entry_o(ctrl_rsp_entry),
    .ctrl_rsp_error_o(ctrl_rsp_error),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid), .mem_rerror_i(mem_rerror)
  );

  always #5 clk = ~clk;

  // Memory model: masked writes, reads returned after mem_lat cycles.
  logic [63:0] mem [0:255];
  int unsigned mem_lat;
  bit          mem_stuck;
  logic [1:0]  mem_err_inj;
  int unsigned req_cnt;
  logic        pend;
  int unsigned cd;
  logic [63:0] pend_data;

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    mem_rerror <= 2'b00;
    if (pend) begin
      if (cd <= 1) begin
        mem_rvalid <= 1'b1; mem_rdata <= pend_data; mem_rerror <= mem_err_inj; pend <= 1'b0;
      end else cd <= cd - 1;
    end
    if (mem_req) begin
      req_cnt <= req_cnt + 1;
      if (mem_write) mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
      else if (!mem_stuck) begin
        if (mem_lat == 1) begin
          mem_rvalid <= 1'b1; mem_rdata <= mem[mem_addr]; mem_rerror <= mem_err_inj;
        end else begin
          pend <= 1'b1; cd <= mem_lat - 1; pend_data <= mem[mem_addr];
        end
      end
    end
  end

  typedef struct {
    bit          is_csr;
    logic [63:0] data;
    bit          err;
  } exp_t;

  typedef struct {
    bit          is_csr;
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    bit          exp_req;
    logic [63:0] exp_mask;
    logic [63:0] exp_data;
    bit          exp_err;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_rsp(input bit is_csr, input logic [63:0] d, input logic e);
    exp_t x;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_rsp: got csr=%0b data=%h err=%b want none", is_csr, d, e);
    end else begin
      x = sb.pop_front();
      if (x.is_csr != is_csr || x.data !== d || x.err != e) begin
        bad++;
        $display("FAIL rsp: got csr=%0b data=%h err=%b want csr=%0b data=%h err=%b",
                 is_csr, d, e, x.is_csr, x.data, x.err);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ctrl_rsp_valid) check_rsp(1'b0, ctrl_rsp_entry, ctrl_rsp_error);
      if (csr_rsp_valid && csr_rsp_ready) check_rsp(1'b1, {32'h0, csr_rsp_rdata}, csr_rsp_error);
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_rsp_timeout: pending=%0d want=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_req(input vec_t v, input string name);
    int unsigned base;
    int n = 0;
    logic [7:0] exp_idx;
    @(negedge clk);
    base = req_cnt;
    exp_idx = v.is_csr ? v.addr[8:1] : v.addr[7:0];
    if (v.is_csr) begin
      csr_req_valid = 1'b1; csr_req_write = v.wr; csr_req_addr = v.addr; csr_req_wdata = v.wdata;
    end else begin
      ctrl_req_valid = 1'b1; ctrl_req_idx = v.addr[7:0];
    end
    #1;
    while (!(v.is_csr ? csr_req_ready : ctrl_req_ready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL %s_grant: got no ready want ready", name);
    end else begin
      chk({name, "_memreq"}, 64'(mem_req), 64'(v.exp_req));
      if (v.exp_req) begin
        chk({name, "_addr"}, 64'(mem_addr), 64'(exp_idx));
        chk({name, "_wmask"}, mem_wmask, v.exp_mask);
        if (v.wr) chk({name, "_wdata"}, mem_wdata, {v.wdata, v.wdata});
      end
      sb.push_back('{v.is_csr, v.exp_data, v.exp_err});
    end
    @(posedge clk); #1;
    csr_req_valid = 1'b0; ctrl_req_valid = 1'b0;
    wait_drain(name);
    @(negedge clk);
    chk({name, "_reqcnt"}, 64'(req_cnt - base), 64'(v.exp_req));
  endtask

  // Single read with accept-to-response cycle count.
  task automatic rd_seq(input string name, input bit is_csr, input logic [8:0] addr,
                        input logic [63:0] exp_data, input bit exp_err, input int exp_cyc);
    int cyc;
    @(negedge clk);
    if (is_csr) begin csr_req_valid = 1'b1; csr_req_write = 1'b0; csr_req_addr = addr; end
    else begin ctrl_req_valid = 1'b1; ctrl_req_idx = addr[7:0]; end
    #1;
    chk({name, "_ready"}, 64'(is_csr ? csr_req_ready : ctrl_req_ready), 64'd1);
    sb.push_back('{is_csr, exp_data, exp_err});
    @(posedge clk); #1;
    csr_req_valid = 1'b0; ctrl_req_valid = 1'b0;
    cyc = 1;
    while (!(is_csr ? csr_rsp_valid : ctrl_rsp_valid) && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    chk({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
    if (!is_csr) begin
      @(posedge clk); #1;
      chk({name, "_pulse"}, 64'(ctrl_rsp_valid), 64'd0);
    end
    wait_drain(name);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1; rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1; rst = 1'b0;
  endtask

  vec_t vecs[13];
  bit   order[3];
  int   bad_cyc, seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1, 1, 9'h005, 32'hDEADBEEF, 1, 64'hFFFFFFFF_00000000, 64'h0, 0};
    vecs[1]  = '{0, 0, 9'd2,   32'h0,        1, 64'h0, 64'hDEADBEEF_00000000, 0};
    vecs[2]  = '{1, 0, 9'h005, 32'h0,        1, 64'h0, 64'h00000000_DEADBEEF, 0};
    vecs[3]  = '{1, 0, 9'h004, 32'h0,        1, 64'h0, 64'h0, 0};
    vecs[4]  = '{1, 1, 9'h004, 32'h12345678, 1, 64'h00000000_FFFFFFFF, 64'h0, 0};
    vecs[5]  = '{0, 0, 9'd2,   32'h0,        1, 64'h0, 64'hDEADBEEF_12345678, 0};
    vecs[6]  = '{1, 0, 9'h004, 32'h0,        1, 64'h0, 64'h00000000_12345678, 0};
    vecs[7]  = '{0, 0, 9'd200, 32'h0,        0, 64'h0, 64'h0, 1};
    vecs[8]  = '{0, 0, 9'd127, 32'h0,        1, 64'h0, 64'h0, 0};
    vecs[9]  = '{1, 0, 9'h0FF, 32'h0,        1, 64'h0, 64'h0, 0};
    vecs[10] = '{1, 0, 9'h100, 32'h0,        0, 64'h0, 64'h0, 1};
    vecs[11] = '{1, 1, 9'h1FF, 32'hCAFEF00D, 0, 64'h0, 64'h0, 1};
    vecs[12] = '{0, 0, 9'd128, 32'h0,        0, 64'h0, 64'h0, 1};

    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem_lat = 1; mem_stuck = 1'b0; mem_err_inj = 2'b00; req_cnt = 0; pend = 1'b0; cd = 0;
    pend_data = 64'h0; mem_rvalid = 1'b0; mem_rerror = 2'b00; mem_rdata = 64'h0;
    rst = 1'b1;
    csr_req_valid = 1'b1; csr_req_write = 1'b1; csr_req_addr = 9'h005; csr_req_wdata = 32'h1;
    ctrl_req_valid = 1'b1; ctrl_req_idx = 8'd2; csr_rsp_ready = 1'b1;

    // Outputs quiet while reset is held, even with requests pending.
    repeat (3) @(negedge clk);
    chk("rst_ready", {62'h0, csr_req_ready, ctrl_req_ready}, 64'h0);
    chk("rst_mem", {61'h0, mem_req, mem_write, |mem_wmask}, 64'h0);
    chk("rst_rsp_valid", {62'h0, csr_rsp_valid, ctrl_rsp_valid}, 64'h0);
    chk("rst_rsp_data", {csr_rsp_rdata, 30'h0, csr_rsp_error, ctrl_rsp_error}, 64'h0);
    chk("rst_entry", ctrl_rsp_entry, 64'h0);
    csr_req_valid = 1'b0; ctrl_req_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 13; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    rd_seq("lat1", 1'b0, 9'd2, 64'hDEADBEEF_12345678, 1'b0, 2);
    mem_err_inj = 2'b10;
    rd_seq("rerror", 1'b0, 9'd2, 64'hDEADBEEF_12345678, 1'b1, 2);
    mem_err_inj = 2'b00;
    mem_stuck = 1'b1;
    rd_seq("tmo_stuck", 1'b1, 9'h005, 64'h0, 1'b1, Tmo + 1);
    mem_stuck = 1'b0; mem_lat = Tmo;
    rd_seq("tmo_edge_ok", 1'b1, 9'h005, 64'h00000000_DEADBEEF, 1'b0, Tmo + 1);
    mem_lat = Tmo + 1;
    rd_seq("tmo_edge_late", 1'b1, 9'h005, 64'h0, 1'b1, Tmo + 1);
    mem_lat = 1;
    repeat (4) @(negedge clk);

    // Three simultaneous CSR/controller requests after reset.
    do_reset(2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      csr_req_valid = 1'b1; csr_req_write = 1'b0; csr_req_addr = 9'h004;
      ctrl_req_valid = 1'b1; ctrl_req_idx = 8'd2;
      #1;
      chk($sformatf("arb%0d_onehot", k), 64'(csr_req_ready) + 64'(ctrl_req_ready), 64'd1);
      order[k] = ctrl_req_ready;
      if (ctrl_req_ready) sb.push_back('{1'b0, 64'hDEADBEEF_12345678, 1'b0});
      else                sb.push_back('{1'b1, 64'h00000000_12345678, 1'b0});
      @(posedge clk); #1;
      csr_req_valid = 1'b0; ctrl_req_valid = 1'b0;
      wait_drain($sformatf("arb%0d", k));
    end
    chk("arb_order", {61'h0, order[0], order[1], order[2]}, 64'b101);

    // CSR response held off for 10 cycles with a controller request waiting.
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    csr_req_valid = 1'b1; csr_req_write = 1'b0; csr_req_addr = 9'h005;
    #1;
    chk("stall_accept", 64'(csr_req_ready), 64'd1);
    sb.push_back('{1'b1, 64'h00000000_DEADBEEF, 1'b0});
    @(posedge clk); #1;
    csr_req_valid = 1'b0; ctrl_req_valid = 1'b1; ctrl_req_idx = 8'd2;
    seen = 0;
    while (!csr_rsp_valid && seen < 40) begin @(negedge clk); seen++; end
    bad_cyc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!(csr_rsp_valid && csr_rsp_rdata == 32'hDEADBEEF && !csr_rsp_error && !ctrl_req_ready))
        bad_cyc++;
    end
    chk("stall_stable", 64'(bad_cyc), 64'd0);
    chk("stall_pending", 64'(sb.size()), 64'd1);
    @(posedge clk); #1;
    ctrl_req_valid = 1'b0; csr_rsp_ready = 1'b1;
    wait_drain("stall");

    // Reset while a read is outstanding; the late data must be dropped.
    mem_lat = 6;
    @(negedge clk);
    ctrl_req_valid = 1'b1; ctrl_req_idx = 8'd2;
    #1;
    chk("rdrst_accept", 64'(ctrl_req_ready), 64'd1);
    @(posedge clk); #1;
    ctrl_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ctrl_rsp_valid || csr_rsp_valid) seen++;
    end
    chk("rdrst_no_rsp", 64'(seen), 64'd0);
    mem_lat = 1;
    do_req(vecs[6], "rdrst_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
